// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle CPU sequencer: FSM states, ALU ops,
// opcode/funct values, datapath mux selects and the bundled control word.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_LW    = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_op_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic MEM_SEL_PC     = 1'b0;
  localparam logic MEM_SEL_ALUREG = 1'b1;
  localparam logic DST_RD         = 1'b0;
  localparam logic DST_RT         = 1'b1;
  localparam logic WD_MDR         = 1'b0;
  localparam logic WD_ALUREG      = 1'b1;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_AREG = 2'd1;
  localparam logic [1:0] SRC_A_BEN  = 2'd2;
  localparam logic [1:0] SRC_A_ZERO = 2'd3;

  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM32   = 2'd1;
  localparam logic [1:0] SRC_B_BREG    = 2'd2;
  localparam logic [1:0] SRC_B_FOUR    = 2'd3;

  localparam logic [1:0] PC_SRC_SEL     = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd1;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'd2;
  localparam logic [1:0] PC_SRC_ALUREG  = 2'd3;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       reg_we;
    logic       mem_req;
    logic       mem_we;
    logic       jal;
    logic       mem_sel;
    logic       reg_dst;
    logic       reg_in;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_t    alu_op;
    logic       fault;
  } ctrl_t;

  typedef struct packed {
    logic    valid;
    alu_op_t op;
  } funct_dec_t;

  function automatic funct_dec_t decode_funct(input logic [5:0] funct);
    funct_dec_t d;
    d.valid = 1'b1;
    case (funct)
      FN_ADD:  d.op = ALU_ADD;
      FN_SUB:  d.op = ALU_SUB;
      FN_AND:  d.op = ALU_AND;
      FN_OR:   d.op = ALU_OR;
      FN_XOR:  d.op = ALU_XOR;
      FN_NOR:  d.op = ALU_NOR;
      FN_SLT:  d.op = ALU_SLT;
      default: begin
        d.valid = 1'b0;
        d.op    = ALU_ADD;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait and flags the cycle
// whose end would complete the TIMEOUT-th such wait.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  input  logic leave,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  assign expire = active && !mem_ready && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else if (leave || !active || mem_ready) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mcpu_seq_ctrl.sv
// Multicycle MIPS-style sequencer: decodes the IR into per-state datapath
// controls, guards memory waits with a timeout and counts retired instructions.
module mcpu_seq_ctrl
  import mcpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             a_we,
  output logic             b_we,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             jal,
  output logic             mem_sel,
  output logic             reg_dst,
  output logic             reg_in,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  ctrl_t            ctrl, ctrl_gated;
  funct_dec_t       fdec;
  logic [CNT_W-1:0] instret_q;
  logic             wait_state, timeout, retire;

  logic [5:0] opcode, funct;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Register/immediate fields belong to the datapath, not to sequencing.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .active    (wait_state),
    .mem_ready (mem_ready),
    .leave     (state_d != state_q),
    .expire    (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    fdec    = decode_funct(funct);
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_sel   = MEM_SEL_PC;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU_OUT;
        if (mem_ready) begin
          ctrl.pc_we = 1'b1;
          ctrl.ir_we = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.a_we      = 1'b1;
        ctrl.b_we      = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        // ALUreg still holds PC+4 from FETCH, which is the JAL link value.
        if (opcode == OP_JAL) begin
          ctrl.reg_we = 1'b1;
          ctrl.jal    = 1'b1;
          ctrl.reg_in = WD_ALUREG;
        end
        case (opcode)
          OP_R:             state_d = S_EXEC_R;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J, OP_JAL:     state_d = S_JUMP;
          OP_ADDI, OP_XORI: state_d = S_IMM_EXEC;
          default:          state_d = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_AREG;
        ctrl.alu_src_b = SRC_B_BREG;
        ctrl.alu_op    = fdec.op;
        state_d        = fdec.valid ? S_WB_R : S_FAULT;
      end
      S_WB_R: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = DST_RD;
        ctrl.reg_in  = WD_ALUREG;
        state_d      = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_AREG;
        ctrl.alu_src_b = SRC_B_IMM32;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_sel = MEM_SEL_ALUREG;
        if (mem_ready) state_d = S_WB_LW;
      end
      S_WB_LW: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = DST_RT;
        ctrl.reg_in  = WD_MDR;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.mem_sel = MEM_SEL_ALUREG;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_AREG;
        ctrl.alu_src_b = SRC_B_BREG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUREG;
        ctrl.pc_we     = (opcode == OP_BNE) ? ~zero : zero;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_SRC_JUMP;
        ctrl.pc_we  = 1'b1;
        state_d     = S_FETCH;
      end
      S_IMM_EXEC: begin
        ctrl.alu_src_a = SRC_A_AREG;
        ctrl.alu_src_b = SRC_B_IMM32;
        ctrl.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d        = S_IMM_WB;
      end
      S_IMM_WB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = DST_RT;
        ctrl.reg_in  = WD_ALUREG;
        state_d      = S_FETCH;
      end
      S_FAULT: ctrl.fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_WB_R)   || (state_q == S_WB_LW) ||
                   (state_q == S_MEM_WR) || (state_q == S_BRANCH) ||
                   (state_q == S_JUMP)   || (state_q == S_IMM_WB));

  // Reset must silence the bus immediately, even though FETCH itself requests memory.
  assign ctrl_gated = reset ? ctrl : '0;

  assign pc_we     = ctrl_gated.pc_we;
  assign ir_we     = ctrl_gated.ir_we;
  assign a_we      = ctrl_gated.a_we;
  assign b_we      = ctrl_gated.b_we;
  assign reg_we    = ctrl_gated.reg_we;
  assign mem_req   = ctrl_gated.mem_req;
  assign mem_we    = ctrl_gated.mem_we;
  assign jal       = ctrl_gated.jal;
  assign mem_sel   = ctrl_gated.mem_sel;
  assign reg_dst   = ctrl_gated.reg_dst;
  assign reg_in    = ctrl_gated.reg_in;
  assign alu_src_a = ctrl_gated.alu_src_a;
  assign alu_src_b = ctrl_gated.alu_src_b;
  assign pc_src    = ctrl_gated.pc_src;
  assign alu_op    = ctrl_gated.alu_op;
  assign fault     = ctrl_gated.fault;
  assign state     = state_q;
  assign instret   = instret_q;

endmodule

// File: doc/mcpu_seq_ctrl.md
MCPU_SEQ_CTRL -- requirements
Module: mcpu_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max consecutive memory-wait cycles before FAULT (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr  in  32  current IR contents; opcode [31:26], funct [5:0].
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  in  1  memory completes the access this cycle.
REQ-008 SHALL have outputs pc_we, ir_we, a_we, b_we, reg_we, mem_req, mem_we, jal  out  1 each  register, memory and link enables.
REQ-009 SHALL have outputs mem_sel, reg_dst, reg_in  out  1 each  addr 0=PC/1=ALUreg; dst 0=rd/1=rt; wdata 0=MDR/1=ALUreg.
REQ-010 SHALL have outputs alu_src_a, alu_src_b, pc_src  out  2 each  A 0=PC,1=Areg,2=BEN,3=0; B 0=imm<<2,1=imm32,2=Breg,3=4; PC 0=sel,1=jump concat,2=alu_out,3=ALUreg.
REQ-011 SHALL have outputs alu_op  out  3  (ADD0 SUB1 XOR2 SLT3 AND4 NAND5 NOR6 OR7); state  out  4; fault  out  1; instret  out  CNT_W.

Function
REQ-012 States SHALL be FETCH0 DECODE1 EXEC_R2 WB_R3 MEM_ADDR4 MEM_RD5 WB_LW6 MEM_WR7 BRANCH8 JUMP9 IMM_EXEC10 IMM_WB11 FAULT15; encodings 12-14 go to FAULT.
REQ-013 FETCH: mem_req=1, mem_sel=0, alu_src_a=0, alu_src_b=3, ADD, pc_src=2; pc_we and ir_we asserted only in the cycle mem_ready=1, which moves to DECODE; otherwise hold.
REQ-014 DECODE: a_we=b_we=1, alu_src_a=0, alu_src_b=0, ADD (branch target into ALUreg); if opcode JAL(0x03) also reg_we=1, jal=1, reg_in=1 (link = incremented PC).
REQ-015 DECODE next state: R(0x00)->EXEC_R; LW(0x23), SW(0x2b)->MEM_ADDR; BEQ(0x04), BNE(0x05)->BRANCH; J(0x02), JAL->JUMP; ADDI(0x08), XORI(0x0e)->IMM_EXEC; other->FAULT.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=2; funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2a SLT; other funct->FAULT; else ->WB_R.
REQ-017 WB_R: reg_we=1, reg_dst=0, reg_in=1; ->FETCH.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=1, ADD; LW->MEM_RD, SW->MEM_WR.
REQ-019 MEM_RD: mem_req=1, mem_sel=1; ->WB_LW on mem_ready. WB_LW: reg_we=1, reg_dst=1, reg_in=0; ->FETCH.
REQ-020 MEM_WR: mem_req=mem_we=1, mem_sel=1, held until mem_ready; ->FETCH on mem_ready.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=2, SUB, pc_src=3; pc_we = zero for BEQ, ~zero for BNE; ->FETCH.
REQ-022 JUMP: pc_src=1, pc_we=1; ->FETCH. IMM_EXEC: alu_src_a=1, alu_src_b=1, ADD (ADDI) or XOR (XORI); IMM_WB: reg_we=1, reg_dst=1, reg_in=1; ->FETCH.
REQ-023 All enables not listed for a state SHALL be 0; unlisted selects SHALL be 0.
REQ-024 Wait counter SHALL count consecutive mem_ready=0 cycles in FETCH/MEM_RD/MEM_WR, clear on every state change; when the TIMEOUT-th such cycle ends with mem_ready=0, next state SHALL be FAULT.
REQ-025 FAULT: all enables 0, fault=1, sticky until reset.
REQ-026 instret SHALL increment by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from WB_R, WB_LW, MEM_WR, BRANCH, JUMP, IMM_WB.
REQ-027 Minimum latency, zero-wait memory: BEQ/BNE/J/JAL 3, R/SW/ADDI/XORI 4, LW 5 cycles.

Reset
REQ-028 reset=0 SHALL asynchronously force state=FETCH, wait counter=0, instret=0, fault=0, all enables 0, mid-operation included; an in-flight memory access is abandoned.
REQ-029 First FETCH SHALL begin on the first rising clk edge after reset deasserts.

Structure
REQ-030 State, alu_op, opcode/funct and mux-select encodings SHALL live in shared package mcpu_pkg.
REQ-031 The wait counter with timeout compare SHALL be sub-module mem_wait_timer.

Verification
REQ-032 instr=0x00851020 (add $2,$4,$5), mem_ready=1 -> states 0,1,2,3,0; EXEC_R alu_op=0; WB_R reg_we=1, reg_dst=0; instret 0->1.
REQ-033 LW 0x8C820004, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_req=1, mem_sel=1; then WB_LW reg_in=0.
REQ-034 BNE with zero=1 -> BRANCH pc_we=0; BEQ with zero=1 -> pc_we=1, pc_src=3; instret increments both.
REQ-035 JAL 0x0C000010 -> DECODE reg_we=1, jal=1, reg_in=1; JUMP pc_src=1, pc_we=1.
REQ-036 TIMEOUT=16, mem_ready held 0 in FETCH -> state 15, fault=1 after 16 cycles; opcode 0x3F also -> FAULT.
REQ-037 reset=0 asserted mid-MEM_WR -> state=0, mem_we=0, instret=0 immediately, before next clk edge.
